// File: rtl/clock_pkg.sv
// Shared types, constants and helpers for the clock/stopwatch/timer core.
//   mode_t     : top-level operating mode, also driven out on the mode port
//   field_t    : clock field selected for editing in SET mode
//   SEP_CODE   : display nibble rendered as '-' by the downstream decoder
//   DIGITS     : number of display digits
package clock_pkg;

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        SET       = 2'd1,
        STOPWATCH = 2'd2,
        TIMER     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        HOUR = 2'd0,
        MIN  = 2'd1,
        SEC  = 2'd2
    } field_t;

    localparam logic [3:0]  SEP_CODE = 4'hA;
    localparam int unsigned DIGITS   = 8;

    // Binary 0..99 to {tens, ones} BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

    function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max);
        return (v >= max) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] dec_wrap(input logic [6:0] v, input logic [6:0] max);
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

endpackage

// File: rtl/clock_timer_core_bin2_bcd.sv
// Combinational 7-bit (0..99) binary to two BCD nibbles.
//   bin_i  : binary value, 0..99
//   tens_o : tens digit
//   ones_o : ones digit
module bin2_bcd
    import clock_pkg::*;
(
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        {tens_o, ones_o} = bin_to_bcd(bin_i);
    end

endmodule

// File: rtl/clock_timer_core.sv
// Timekeeping core: time-of-day clock, clock set, stopwatch and countdown timer with alarm.
//   clk_i         : system clock
//   rst_i         : synchronous reset, active-high
//   key_mode_i    : one-cycle pulse, advance mode
//   key_sel_i     : one-cycle pulse, select field / run-pause
//   key_dec_i     : one-cycle pulse, decrement / clear
//   key_inc_i     : one-cycle pulse, increment
//   mode_o        : current mode (mode_t encoding)
//   disp_bcd_o    : 8 registered nibbles, [31:28] leftmost; SEP_CODE renders '-'
//   blank_mask_o  : registered, bit7 leftmost digit, 1 = dark
//   alarm_o       : timer expired, held until a key pulse
//   tick_1hz_o    : one-cycle pulse per second of the timebase
module clock_timer_core
    import clock_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned INIT_HOUR = 0,
    parameter int unsigned INIT_MIN  = 0,
    parameter int unsigned INIT_SEC  = 0,
    parameter int unsigned BLINK_TK  = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  key_mode_i,
    input  logic                  key_sel_i,
    input  logic                  key_dec_i,
    input  logic                  key_inc_i,
    output logic [1:0]            mode_o,
    output logic [4*DIGITS-1:0]   disp_bcd_o,
    output logic [DIGITS-1:0]     blank_mask_o,
    output logic                  alarm_o,
    output logic                  tick_1hz_o
);

    localparam int unsigned TickDiv = CLK_FREQ / 100;
    localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned BlinkW  = (BLINK_TK > 1) ? $clog2(BLINK_TK) : 1;
    localparam logic [31:0] InitImage = {bin_to_bcd(7'(INIT_HOUR)), SEP_CODE,
                                         bin_to_bcd(7'(INIT_MIN)), SEP_CODE,
                                         bin_to_bcd(7'(INIT_SEC))};

    logic [PreW-1:0]   presc_q, presc_d;
    logic [6:0]        sub_q, sub_d;
    logic              tick10, tick1hz;
    mode_t             mode_q, mode_d;
    field_t            field_q, field_d;
    logic [6:0]        hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic              sw_run_q, sw_run_d;
    logic [6:0]        sw_min_q, sw_min_d, sw_sec_q, sw_sec_d, sw_cs_q, sw_cs_d;
    logic              tm_run_q, tm_run_d, expire_q, expire_d, alarm_q, alarm_d;
    logic [6:0]        tm_min_q, tm_min_d, tm_sec_q, tm_sec_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;
    logic [31:0]       disp_q, disp_d;
    logic [7:0]        blank_q, blank_d;
    logic              key_any, k_mode, k_sel, k_inc, k_dec;
    logic [6:0]        pair_hi, pair_mid, pair_lo;
    logic [3:0]        hi_t, hi_o, mid_t, mid_o, lo_t, lo_o;

    // Timebase and key decode
    always_comb begin
        tick10  = (presc_q == PreW'(TickDiv - 1));
        tick1hz = tick10 && (sub_q == 7'd99);
        presc_d = tick10 ? '0 : presc_q + 1'b1;
        sub_d   = sub_q;
        if (tick10) sub_d = inc_wrap(sub_q, 7'd99);
        // While the alarm is up, any key only acknowledges it.
        key_any = key_mode_i | key_sel_i | key_inc_i | key_dec_i;
        k_mode  = !alarm_q && key_mode_i;
        k_sel   = !alarm_q && key_sel_i && !key_mode_i;
        k_inc   = !alarm_q && key_inc_i && !key_mode_i && !key_sel_i;
        k_dec   = !alarm_q && key_dec_i && !key_mode_i && !key_sel_i && !key_inc_i;
    end

    // Mode FSM, field select and blink phase
    always_comb begin
        mode_d      = mode_q;
        field_d     = field_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (k_mode) begin
            mode_d = mode_t'(mode_q + 2'd1);
            if (mode_q == SET) field_d = HOUR;
        end else if (k_sel && mode_q == SET) begin
            case (field_q)
                HOUR:    field_d = MIN;
                MIN:     field_d = SEC;
                default: field_d = HOUR;
            endcase
        end
        // Restart the blink on SET entry so the edited field starts lit.
        if (k_mode && mode_q == CLOCK) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (tick10) begin
            if (blink_cnt_q == BlinkW'(BLINK_TK - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Time-of-day clock
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (mode_q == SET) begin
            if (k_inc || k_dec) begin
                case (field_q)
                    HOUR:    hour_d = k_inc ? inc_wrap(hour_q, 7'd23) : dec_wrap(hour_q, 7'd23);
                    MIN:     min_d  = k_inc ? inc_wrap(min_q, 7'd59) : dec_wrap(min_q, 7'd59);
                    default: sec_d  = k_inc ? inc_wrap(sec_q, 7'd59) : dec_wrap(sec_q, 7'd59);
                endcase
            end
        end else if (tick1hz) begin
            sec_d = inc_wrap(sec_q, 7'd59);
            if (sec_q == 7'd59) begin
                min_d = inc_wrap(min_q, 7'd59);
                if (min_q == 7'd59) hour_d = inc_wrap(hour_q, 7'd23);
            end
        end
    end

    // Stopwatch
    always_comb begin
        sw_run_d = sw_run_q;
        sw_min_d = sw_min_q;
        sw_sec_d = sw_sec_q;
        sw_cs_d  = sw_cs_q;
        if (mode_q == STOPWATCH && k_sel) sw_run_d = ~sw_run_q;
        if (mode_q == STOPWATCH && k_dec) begin
            sw_min_d = '0;
            sw_sec_d = '0;
            sw_cs_d  = '0;
        end else if (sw_run_q && tick10) begin
            sw_cs_d = inc_wrap(sw_cs_q, 7'd99);
            if (sw_cs_q == 7'd99) begin
                sw_sec_d = inc_wrap(sw_sec_q, 7'd59);
                if (sw_sec_q == 7'd59) sw_min_d = inc_wrap(sw_min_q, 7'd59);
            end
        end
    end

    // Countdown timer and alarm
    always_comb begin
        tm_run_d = tm_run_q;
        tm_min_d = tm_min_q;
        tm_sec_d = tm_sec_q;
        expire_d = 1'b0;
        alarm_d  = alarm_q;
        if (mode_q == TIMER && !tm_run_q && (k_inc || k_dec)) begin
            tm_min_d = k_inc ? inc_wrap(tm_min_q, 7'd99) : dec_wrap(tm_min_q, 7'd99);
            tm_sec_d = '0;
        end
        if (mode_q == TIMER && k_sel) begin
            if (tm_run_q)                                  tm_run_d = 1'b0;
            else if (tm_min_q != 7'd0 || tm_sec_q != 7'd0) tm_run_d = 1'b1;
        end
        if (tm_run_q && tick1hz) begin
            if (tm_sec_q == 7'd0) begin
                tm_sec_d = 7'd59;
                tm_min_d = tm_min_q - 7'd1;
            end else begin
                tm_sec_d = tm_sec_q - 7'd1;
            end
            if (tm_min_q == 7'd0 && tm_sec_q == 7'd1) begin
                tm_run_d = 1'b0;
                expire_d = 1'b1;
            end
        end
        if (expire_q)     alarm_d = 1'b1;
        else if (key_any) alarm_d = 1'b0;
    end

    // Display mux
    always_comb begin
        pair_hi  = hour_q;
        pair_mid = min_q;
        pair_lo  = sec_q;
        case (mode_q)
            STOPWATCH: begin
                pair_hi  = sw_min_q;
                pair_mid = sw_sec_q;
                pair_lo  = sw_cs_q;
            end
            TIMER: begin
                pair_hi  = tm_min_q;
                pair_mid = 7'd0;
                pair_lo  = tm_sec_q;
            end
            default: ;
        endcase
    end

    bin2_bcd u_bcd_hi  (.bin_i(pair_hi),  .tens_o(hi_t),  .ones_o(hi_o));
    bin2_bcd u_bcd_mid (.bin_i(pair_mid), .tens_o(mid_t), .ones_o(mid_o));
    bin2_bcd u_bcd_lo  (.bin_i(pair_lo),  .tens_o(lo_t),  .ones_o(lo_o));

    always_comb begin
        if (mode_q == TIMER) begin
            disp_d = {hi_t, hi_o, SEP_CODE, SEP_CODE, SEP_CODE, SEP_CODE, lo_t, lo_o};
        end else begin
            disp_d = {hi_t, hi_o, SEP_CODE, mid_t, mid_o, SEP_CODE, lo_t, lo_o};
        end
        blank_d = '0;
        if (alarm_q) begin
            blank_d = {DIGITS{blink_ph_q}};
        end else if (mode_q == SET && blink_ph_q) begin
            case (field_q)
                HOUR:    blank_d = 8'b1100_0000;
                MIN:     blank_d = 8'b0001_1000;
                default: blank_d = 8'b0000_0011;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q     <= '0;
            sub_q       <= '0;
            mode_q      <= CLOCK;
            field_q     <= HOUR;
            hour_q      <= 7'(INIT_HOUR);
            min_q       <= 7'(INIT_MIN);
            sec_q       <= 7'(INIT_SEC);
            sw_run_q    <= 1'b0;
            sw_min_q    <= '0;
            sw_sec_q    <= '0;
            sw_cs_q     <= '0;
            tm_run_q    <= 1'b0;
            tm_min_q    <= '0;
            tm_sec_q    <= '0;
            expire_q    <= 1'b0;
            alarm_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            disp_q      <= InitImage;
            blank_q     <= '0;
        end else begin
            presc_q     <= presc_d;
            sub_q       <= sub_d;
            mode_q      <= mode_d;
            field_q     <= field_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sw_run_q    <= sw_run_d;
            sw_min_q    <= sw_min_d;
            sw_sec_q    <= sw_sec_d;
            sw_cs_q     <= sw_cs_d;
            tm_run_q    <= tm_run_d;
            tm_min_q    <= tm_min_d;
            tm_sec_q    <= tm_sec_d;
            expire_q    <= expire_d;
            alarm_q     <= alarm_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            disp_q      <= disp_d;
            blank_q     <= blank_d;
        end
    end

    assign mode_o       = mode_q;
    assign disp_bcd_o   = disp_q;
    assign blank_mask_o = blank_q;
    assign alarm_o      = alarm_q;
    assign tick_1hz_o   = tick1hz;

endmodule
